// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function codes, class and sequencer state types
package alu_pkg;

    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_SHIFT,
        CLS_MUL,
        CLS_HILO,
        CLS_ILLEGAL
    } fn_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } seq_state_e;

endpackage

// File: rtl/alu_fn_decode.sv
// rtl/alu_fn_decode.sv - combinational function code to operation class decode
//
// Ports:
//   ctrl  in   6-bit function code
//   cls   out  operation class (ALU, SHIFT, MUL, HILO, ILLEGAL)
module alu_fn_decode
    import alu_pkg::*;
(
    input  logic [5:0] ctrl,
    output fn_class_e  cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (ctrl)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = CLS_ALU;
            FN_SRL:                                cls = CLS_SHIFT;
            FN_MULTU:                              cls = CLS_MUL;
            FN_MFHI, FN_MFLO:                      cls = CLS_HILO;
            default:                               cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - serializing request sequencer in front of the ALU/shifter/multiplier
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/ready          request handshake; req_a, req_b, req_ctrl request payload
//   op_a, op_b, op_ctrl      registered operands/function code driven to the datapath
//   mul_start                one-cycle multiplier start pulse
//   alu_result               combinational datapath result for the current op_*
//   rsp_valid/ready          response handshake; rsp_data, rsp_err response payload
//   busy                     sequencer is not idle
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [5:0]        req_ctrl,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [5:0]        op_ctrl,
    output logic              mul_start,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    seq_state_e state, state_next;
    fn_class_e  req_cls;
    logic [7:0] cnt;

    logic load_op;
    logic load_cnt;
    logic dec_cnt;
    logic cap_exec;
    logic cap_zero;
    logic set_err;
    logic start_mul;

    alu_fn_decode u_decode (
        .ctrl (req_ctrl),
        .cls  (req_cls)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        cap_exec   = 1'b0;
        cap_zero   = 1'b0;
        set_err    = 1'b0;
        start_mul  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_cls)
                        CLS_ALU, CLS_SHIFT, CLS_HILO: begin
                            load_op    = 1'b1;
                            state_next = S_EXEC;
                        end
                        CLS_MUL: begin
                            load_op    = 1'b1;
                            load_cnt   = 1'b1;
                            start_mul  = 1'b1;
                            state_next = S_MUL;
                        end
                        default: begin
                            // Operands stay untouched so HI/LO inputs remain stable.
                            set_err    = 1'b1;
                            state_next = S_RESP;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                cap_exec   = 1'b1;
                state_next = S_RESP;
            end
            S_MUL: begin
                if (cnt == 8'd0) begin
                    cap_zero   = 1'b1;
                    state_next = S_RESP;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_ctrl   <= '0;
            mul_start <= 1'b0;
            cnt       <= 8'd0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // Only set from IDLE, so it is high for the first MUL cycle only.
            mul_start <= start_mul;
            if (load_op) begin
                op_a    <= req_a;
                op_b    <= req_b;
                op_ctrl <= req_ctrl;
            end
            if (load_cnt) begin
                cnt <= 8'(MUL_CYCLES - 1);
            end else if (dec_cnt) begin
                cnt <= cnt - 8'd1;
            end
            if (cap_exec) begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end else if (cap_zero) begin
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end else if (set_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Request sequencer that sits directly upstream of the ALU/shifter/multiplier top. It accepts one operation at a time over a valid/ready request channel and drives registered, stable operands and function code into the datapath. For MULTU it pulses the multiplier start and waits out the fixed multiply latency. It then returns the datapath result over a valid/ready response channel.

## Interface
- DATA_W, 32, operand/result width
- MUL_CYCLES, 32, cycles from mul_start to HI/LO valid; legal range 1..255
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B (shift amount in [4:0] for SRL)
- req_ctrl  in  6  function code
- op_a  out  DATA_W  registered operand A to datapath
- op_b  out  DATA_W  registered operand B to datapath
- op_ctrl  out  6  registered function code to datapath
- mul_start  out  1  one-cycle multiplier start pulse
- alu_result  in  DATA_W  datapath result (combinational from op_*)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  captured result
- rsp_err  out  1  unsupported function code
- busy  out  1  high in any state other than IDLE

## Operation
- Supported codes:
  - ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A: class ALU.
  - SRL 6'h02: class SHIFT.
  - MULTU 6'h19: class MUL.
  - MFHI 6'h10, MFLO 6'h12: class HILO.
  - Any other code: class ILLEGAL.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch req_a/b/ctrl into op_a/b/ctrl.
    - ALU, SHIFT or HILO: go to EXEC.
    - MUL: go to MUL.
    - ILLEGAL: go to RESP with rsp_err=1, rsp_data=0, op_* unchanged (not latched).
  - EXEC: one cycle. Capture alu_result into rsp_data, rsp_err=0, go to RESP.
  - MUL: mul_start=1 in the first MUL cycle only. Down-counter loads MUL_CYCLES-1 on entry and decrements each cycle. At count 0, set rsp_data=0, rsp_err=0, go to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_err held. On rsp_ready, go to IDLE.
- op_a/op_b/op_ctrl hold their value outside accepts, so downstream HI/LO and multiplier inputs stay stable until the next accepted non-ILLEGAL request.
- Requests are strictly serialized, so MFHI/MFLO after MULTU always reads the completed product. No bypass or hazard logic.
- req_ready is low in every state except IDLE. A request held during busy is accepted on the first IDLE cycle.

## Timing
- Reset values: op_a=0, op_b=0, op_ctrl=0, mul_start=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, counter=0, state=IDLE (so req_ready=1).
- Accept at edge t (req_valid & req_ready):
  - ALU/SHIFT/HILO: op_* valid from t+1; rsp_valid from t+2.
  - MULTU: mul_start high during cycle t+1; rsp_valid from t+1+MUL_CYCLES.
  - ILLEGAL: rsp_valid from t+1.
- Back-to-back: response handshake at edge r means state is IDLE after r; the earliest next accept is edge r+1.
- rsp_ready may be held high in advance; the response still lasts at least one cycle.
- MUL_CYCLES=1: the MUL state lasts one cycle, with mul_start and exit in the same cycle.
- Reset mid-operation: immediate return to IDLE, pending response discarded, mul_start deasserted, counter cleared. No response is ever issued for the aborted request.

## Structure
- Shared package alu_pkg:
  - function-code localparams (FN_ADD … FN_MFLO)
  - class enum {CLS_ALU, CLS_SHIFT, CLS_MUL, CLS_HILO, CLS_ILLEGAL}
  - FSM state enum {S_IDLE, S_EXEC, S_MUL, S_RESP}
- One natural sub-module: alu_fn_decode (combinational req_ctrl → class). The FSM, counter and registers live in alu_issue_seq.

## Test plan
- Reset with req_valid=1 held → all outputs 0, req_ready=1; after release, request ADD A=5 B=7 accepted on the first edge → op_ctrl=6'h20, rsp_data=12 at t+2, rsp_err=0.
- MULTU A=3 B=4 with MUL_CYCLES=32 → exactly one mul_start cycle at t+1; rsp_valid at t+33, rsp_data=0; following MFLO → rsp_data=12, and MFHI → 0.
- Illegal code 6'h3F → rsp_valid at t+1, rsp_err=1, rsp_data=0; op_* keep the previous values.
- SRL A=32'h80000000 B=4 with rsp_ready low for 5 cycles → rsp_valid and rsp_data=32'h08000000 held stable for 5 cycles, req_ready=0 throughout.
- rst asserted in the 10th MUL cycle → state IDLE, no rsp_valid; a new SUB A=1 B=2 completes with rsp_data=32'hFFFFFFFF.
- Back-to-back stream of 4 ADDs with rsp_ready=1 → each accept exactly 3 cycles apart, results in order.
